// File: rtl/ahb_lite_master.sv
// rtl/ahb_lite_master.sv - single-master AHB-Lite bus interface
// Converts local commands into SINGLE or 4-beat incrementing AHB-Lite transfers.
module ahb_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic                  cmd_burst4,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [1:0]            HTRANS,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic [DATA_WIDTH-1:0] HRDATA
);

    typedef enum logic {IDLE, XFER} state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_SINGLE = 3'b000;
    localparam logic [2:0] BU_INCR   = 3'b001;
    localparam logic [2:0] BU_INCR4  = 3'b011;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic                  hwrite_q, hwrite_d;
    logic [2:0]            hsize_q, hsize_d;
    logic [2:0]            hburst_q, hburst_d;
    logic [1:0]            htrans_q, htrans_d;
    logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  wr_pop_q, wr_pop_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [1:0]            addr_left_q, addr_left_d;
    logic [2:0]            data_left_q, data_left_d;
    logic                  dphase_q, dphase_d;

    logic [2:0]            size_clamp;
    logic [ADDR_WIDTH-1:0] aligned_addr;
    logic [10:0]           burst_end;
    logic [ADDR_WIDTH-1:0] addr_step;

    always_comb begin
        size_clamp = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
        case (size_clamp)
            3'd1:    aligned_addr = {cmd_addr[ADDR_WIDTH-1:1], 1'b0};
            3'd2:    aligned_addr = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
            default: aligned_addr = cmd_addr;
        endcase
        // Byte offset of the last beat within the 1KB page; bit 10 set means the burst crosses it.
        burst_end = {1'b0, aligned_addr[9:0]} + (11'd3 << size_clamp);
        addr_step = ADDR_WIDTH'(1) << hsize_q[1:0];
    end

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hburst_d    = hburst_q;
        htrans_d    = htrans_q;
        hwdata_d    = hwdata_q;
        rd_data_d   = rd_data_q;
        cmd_ready_d = cmd_ready_q;
        addr_left_d = addr_left_q;
        data_left_d = data_left_q;
        dphase_d    = dphase_q;
        wr_pop_d    = 1'b0;
        rd_valid_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    haddr_d     = aligned_addr;
                    hwrite_d    = cmd_write;
                    hsize_d     = size_clamp;
                    htrans_d    = TR_NONSEQ;
                    hburst_d    = !cmd_burst4 ? BU_SINGLE :
                                  (burst_end > 11'd1023) ? BU_INCR : BU_INCR4;
                    addr_left_d = cmd_burst4 ? 2'd3 : 2'd0;
                    data_left_d = cmd_burst4 ? 3'd4 : 3'd1;
                    dphase_d    = 1'b0;
                    cmd_ready_d = 1'b0;
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (!HREADY) begin
                    // First ERROR cycle: withdraw any pending address so no further beats start.
                    if (dphase_q && HRESP) begin
                        htrans_d    = TR_IDLE;
                        addr_left_d = 2'd0;
                    end
                end else if (dphase_q && HRESP) begin
                    err_d       = 1'b1;
                    done_d      = 1'b1;
                    cmd_ready_d = 1'b1;
                    htrans_d    = TR_IDLE;
                    dphase_d    = 1'b0;
                    addr_left_d = 2'd0;
                    data_left_d = 3'd0;
                    state_d     = IDLE;
                end else begin
                    if (dphase_q) begin
                        if (!hwrite_q) begin
                            rd_data_d  = HRDATA;
                            rd_valid_d = 1'b1;
                        end
                        data_left_d = data_left_q - 3'd1;
                        if (data_left_q == 3'd1) begin
                            done_d      = 1'b1;
                            cmd_ready_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                    if (htrans_q != TR_IDLE) begin
                        dphase_d = 1'b1;
                        if (hwrite_q) begin
                            hwdata_d = wr_data;
                            wr_pop_d = 1'b1;
                        end
                        if (addr_left_q != 2'd0) begin
                            haddr_d     = haddr_q + addr_step;
                            htrans_d    = TR_SEQ;
                            addr_left_d = addr_left_q - 2'd1;
                        end else begin
                            htrans_d = TR_IDLE;
                        end
                    end else begin
                        dphase_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'd0;
            hburst_q    <= BU_SINGLE;
            htrans_q    <= TR_IDLE;
            hwdata_q    <= '0;
            rd_data_q   <= '0;
            cmd_ready_q <= 1'b1;
            wr_pop_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            addr_left_q <= 2'd0;
            data_left_q <= 3'd0;
            dphase_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hburst_q    <= hburst_d;
            htrans_q    <= htrans_d;
            hwdata_q    <= hwdata_d;
            rd_data_q   <= rd_data_d;
            cmd_ready_q <= cmd_ready_d;
            wr_pop_q    <= wr_pop_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            addr_left_q <= addr_left_d;
            data_left_q <= data_left_d;
            dphase_q    <= dphase_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_pop    = wr_pop_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = hburst_q;
    assign HTRANS    = htrans_q;
    assign HWDATA    = hwdata_q;

endmodule
